bottle_conveyor_ctrl: RTL

- Downstream stage of the pill-filling counter. Consumes its one-cycle "bottle complete" pulse, runs the conveyor for a fixed number of cycles to index the next bottle, and packs bottles into boxes.
- Drives the filling stage's enable so that pills are counted only while a bottle sits under the chute.
- Reports bottles-in-box, completed boxes, and a sticky overrun error.

---
 rtl/bottle_conveyor_ctrl_pkg.sv | 14 +
 rtl/bottle_conveyor_ctrl_move_timer.sv | 28 ++
 rtl/bottle_conveyor_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/bottle_conveyor_ctrl_pkg.sv
// rtl/bottle_conveyor_ctrl_pkg.sv - shared state encoding and default line parameters
package bottle_conveyor_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_BOX = 2'd0,
    FILL     = 2'd1,
    MOVE     = 2'd2,
    BOX_OUT  = 2'd3
  } state_t;

  localparam int DEF_MOVE_CYCLES = 8;
  localparam int DEF_BOX_SIZE    = 12;

endpackage

// File: rtl/bottle_conveyor_ctrl_move_timer.sv
// rtl/bottle_conveyor_ctrl_move_timer.sv - conveyor index timer with terminal count
module move_timer #(
  parameter int MOVE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(MOVE_CYCLES - 1));

endmodule

// File: rtl/bottle_conveyor_ctrl.sv
// rtl/bottle_conveyor_ctrl.sv - bottle indexing and box packing sequencer
module bottle_conveyor_ctrl
  import bottle_conveyor_ctrl_pkg::*;
#(
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int BOX_SIZE    = DEF_BOX_SIZE,
  parameter int BOX_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bottle_done,
  input  logic             box_ready,
  input  logic             clr_err,
  output logic             fill_en,
  output logic             conv_on,
  output logic [7:0]       bottles_in_box,
  output logic             box_done,
  output logic [BOX_W-1:0] total_boxes,
  output logic             overrun
);

  localparam logic [7:0] BOX_SIZE_B = 8'(BOX_SIZE);

  state_t     state;
  state_t     next_state;
  logic       tc;
  logic       timer_clr;
  logic       timer_en;
  logic [7:0] bib_inc;

  assign bib_inc   = bottles_in_box + 8'd1;
  assign timer_clr = (state == FILL) && bottle_done;
  // Hold the timer at terminal count so it never wraps during the exit cycle.
  assign timer_en  = (state == MOVE) && !tc;

  move_timer #(
    .MOVE_CYCLES(MOVE_CYCLES)
  ) u_move_timer (
    .clk(clk),
    .rst(rst),
    .clr(timer_clr),
    .en (timer_en),
    .tc (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_BOX;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    fill_en    = 1'b0;
    conv_on    = 1'b0;
    box_done   = 1'b0;
    unique case (state)
      WAIT_BOX: begin
        if (box_ready) next_state = FILL;
      end
      FILL: begin
        fill_en = 1'b1;
        if (bottle_done) next_state = MOVE;
      end
      MOVE: begin
        conv_on = 1'b1;
        if (tc) next_state = (bib_inc == BOX_SIZE_B) ? BOX_OUT : FILL;
      end
      BOX_OUT: begin
        box_done   = 1'b1;
        next_state = WAIT_BOX;
      end
      default: next_state = WAIT_BOX;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bottles_in_box <= '0;
      total_boxes    <= '0;
    end else if (state == MOVE && tc) begin
      bottles_in_box <= bib_inc;
    end else if (state == BOX_OUT) begin
      bottles_in_box <= '0;
      if (total_boxes != '1) total_boxes <= total_boxes + BOX_W'(1);
    end
  end

  // A stray completion pulse outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (bottle_done && state != FILL) begin
      overrun <= 1'b1;
    end else if (clr_err) begin
      overrun <= 1'b0;
    end
  end

endmodule
